// File: rtl/fetch_seq_pkg.sv
// Shared state encodings and opcode constants for the fetch/execute sequencer.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_UPDATE = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BEQ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: absolute jump, taken relative branch, or sequential step.
module pc_next_calc #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] imm,
    input  logic              is_jump,
    input  logic              is_branch,
    input  logic              taken,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_inc;

    // Branch target is relative to the following instruction; all sums wrap.
    always_comb begin
        pc_inc  = pc + ADDR_W'(1);
        next_pc = pc_inc;
        if (is_jump) begin
            next_pc = imm;
        end else if (is_branch && taken) begin
            next_pc = pc_inc + imm;
        end
    end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/execute/update controller owning the architectural PC.
module fetch_exec_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              exec_start,
    input  logic              ex_done,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fault
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    state_t            st;
    logic [CNT_W-1:0]  wait_cnt;
    logic              taken;
    logic [3:0]        ir_op;
    logic [3:0]        rdata_op;
    logic [ADDR_W-1:0] next_pc;

    assign ir_op     = ir[DATA_W-1 -: 4];
    assign rdata_op  = imem_rdata[DATA_W-1 -: 4];
    assign imem_addr = pc;
    assign state     = st;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc        (pc),
        .imm       (ADDR_W'(ir[7:0])),
        .is_jump   (ir_op == OP_JMP),
        .is_branch (ir_op == OP_BEQ),
        .taken     (taken),
        .next_pc   (next_pc)
    );

    // Outputs are registered alongside the state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            pc         <= '0;
            ir         <= '0;
            ir_valid   <= 1'b0;
            imem_req   <= 1'b0;
            exec_start <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            wait_cnt   <= '0;
            taken      <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        st <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    wait_cnt <= '0;
                    imem_req <= 1'b1;
                    st       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_ready) begin
                        ir         <= imem_rdata;
                        ir_valid   <= 1'b1;
                        imem_req   <= 1'b0;
                        exec_start <= (rdata_op != OP_HALT);
                        st         <= ST_DECODE;
                    end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        st       <= ST_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    exec_start <= 1'b0;
                    if (ir_op == OP_HALT) begin
                        ir_valid <= 1'b0;
                        halted   <= 1'b1;
                        st       <= ST_HALT;
                    end else begin
                        st <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (ex_done) begin
                        taken <= branch_taken;
                        st    <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    pc       <= next_pc;
                    ir_valid <= 1'b0;
                    st       <= ST_FETCH;
                end
                ST_HALT: begin
                end
                ST_FAULT: begin
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Self-checking bench: instruction table plus hand-written timeout, halt and reset sequences.
module tb_fetch_exec_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        exec_start;
    logic        ex_done;
    logic        branch_taken;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        halted;
    logic        fault;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_pc;
    logic [7:0] exp_q[$];
    logic [2:0] prev_state;

    typedef struct {
        logic [15:0] instr;
        logic        tk;
        int          rdy_dly;
        int          done_dly;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vecs[13];

    fetch_exec_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .exec_start   (exec_start),
        .ex_done      (ex_done),
        .branch_taken (branch_taken),
        .pc           (pc),
        .state        (state),
        .halted       (halted),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each UPDATE->FETCH transition retires one expected PC.
    initial prev_state = 3'd0;
    always @(negedge clk) begin
        if (prev_state == 3'd5 && state == 3'd1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pc_update", 32'(pc), 32'hFFFF_FFFF);
            end else begin
                check("pc_update", 32'(pc), 32'(exp_q.pop_front()));
            end
        end
        prev_state = state;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_ir"}, 32'(ir), 32'd0);
        check({tag, "_ctl"}, 32'({ir_valid, imem_req, exec_start, halted, fault}), 32'd0);
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check_reset_vals(tag);
        step();
        reset    = 1'b0;
        model_pc = 8'h00;
        step();
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_fetch", 32'(state), 32'd1);
    endtask

    // Runs one non-HALT instruction from FETCH back to FETCH.
    task automatic run_instr(input logic [15:0] instr, input logic tk, input int rdy_dly,
                             input int done_dly, input logic [7:0] exp_pc);
        check("fetch_state", 32'(state), 32'd1);
        check("fetch_ir_valid", 32'(ir_valid), 32'd0);
        step();
        check("wait_state", 32'(state), 32'd2);
        check("wait_req", 32'(imem_req), 32'd1);
        check("wait_addr", 32'(imem_addr), 32'(model_pc));
        for (int k = 0; k < rdy_dly; k++) begin
            step();
            check("wait_hold", 32'(state), 32'd2);
        end
        imem_ready = 1'b1;
        imem_rdata = instr;
        step();
        imem_ready = 1'b0;
        imem_rdata = 16'h0000;
        check("decode_state", 32'(state), 32'd3);
        check("decode_ir", 32'(ir), 32'(instr));
        check("decode_ctl", 32'({ir_valid, exec_start, imem_req}), 32'b110);
        step();
        check("exec_state", 32'(state), 32'd4);
        check("exec_start_pulse", 32'(exec_start), 32'd0);
        for (int k = 0; k < done_dly; k++) begin
            branch_taken = ~tk;
            step();
            check("exec_hold", 32'(state), 32'd4);
        end
        ex_done      = 1'b1;
        branch_taken = tk;
        exp_q.push_back(exp_pc);
        step();
        ex_done      = 1'b0;
        branch_taken = 1'b0;
        check("update_state", 32'(state), 32'd5);
        check("update_ir_valid", 32'(ir_valid), 32'd1);
        step();
        model_pc = exp_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h1000, 1'b0, 0,  0, 8'h01};
        vecs[1]  = '{16'h2000, 1'b0, 2,  1, 8'h02};
        vecs[2]  = '{16'h3000, 1'b1, 0,  3, 8'h03};
        vecs[3]  = '{16'hC040, 1'b0, 0,  0, 8'h40};
        vecs[4]  = '{16'hD005, 1'b1, 1,  0, 8'h46};
        vecs[5]  = '{16'hC040, 1'b1, 0,  2, 8'h40};
        vecs[6]  = '{16'hD005, 1'b0, 0,  0, 8'h41};
        vecs[7]  = '{16'h1000, 1'b1, 14, 0, 8'h42};
        vecs[8]  = '{16'hC010, 1'b0, 0,  0, 8'h10};
        vecs[9]  = '{16'hD0FF, 1'b1, 0,  1, 8'h10};
        vecs[10] = '{16'hC0FF, 1'b0, 3,  0, 8'hFF};
        vecs[11] = '{16'h5000, 1'b0, 0,  0, 8'h00};
        vecs[12] = '{16'hD0FF, 1'b0, 0,  0, 8'h01};

        reset        = 1'b1;
        start        = 1'b0;
        imem_ready   = 1'b0;
        imem_rdata   = 16'h0000;
        ex_done      = 1'b0;
        branch_taken = 1'b0;
        model_pc     = 8'h00;
        step();
        check_reset_vals("por");
        reset = 1'b0;

        // Idle holds; stray datapath strobes outside EXEC are ignored.
        ex_done      = 1'b1;
        branch_taken = 1'b1;
        imem_ready   = 1'b1;
        repeat (3) step();
        ex_done      = 1'b0;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        check("idle_hold_state", 32'(state), 32'd0);
        check("idle_hold_pc", 32'(pc), 32'd0);

        start_run();
        foreach (vecs[i]) begin
            run_instr(vecs[i].instr, vecs[i].tk, vecs[i].rdy_dly, vecs[i].done_dly, vecs[i].exp_pc);
        end

        // Timeout: no ready across MAX_WAIT WAIT cycles -> sticky FAULT.
        check("to_fetch", 32'(state), 32'd1);
        step();
        for (int k = 1; k < 15; k++) begin
            step();
            check("to_wait_hold", 32'(state), 32'd2);
        end
        step();
        check("fault_state", 32'(state), 32'd7);
        check("fault_flag", 32'(fault), 32'd1);
        check("fault_req", 32'(imem_req), 32'd0);
        check("fault_pc", 32'(pc), 32'(model_pc));
        start      = 1'b1;
        imem_ready = 1'b1;
        ex_done    = 1'b1;
        repeat (4) step();
        start      = 1'b0;
        imem_ready = 1'b0;
        ex_done    = 1'b0;
        check("fault_sticky", 32'({state, fault}), 32'({3'd7, 1'b1}));
        apply_reset("fault_rst");

        // HALT at pc=7: no exec_start, absorbing, pc unchanged.
        start_run();
        run_instr(16'hC007, 1'b0, 0, 0, 8'h07);
        step();
        imem_ready = 1'b1;
        imem_rdata = 16'hF000;
        step();
        imem_ready = 1'b0;
        check("halt_decode_state", 32'(state), 32'd3);
        check("halt_no_exec", 32'(exec_start), 32'd0);
        step();
        check("halt_state", 32'(state), 32'd6);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'h07);
        check("halt_exec", 32'(exec_start), 32'd0);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            step();
        end
        check("halt_sticky", 32'({state, halted}), 32'({3'd6, 1'b1}));
        check("halt_pc_hold", 32'(pc), 32'h07);
        apply_reset("halt_rst");

        // Reset mid-EXEC with ex_done stalled: abort with no PC update.
        start_run();
        step();
        imem_ready = 1'b1;
        imem_rdata = 16'h1000;
        step();
        imem_ready = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            step();
        end
        check("stall_exec", 32'(state), 32'd4);
        apply_reset("exec_rst");
        repeat (2) step();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_pc", 32'(pc), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
